sign_message_writer: RTL and testbench

Message-entry side of the relay sign's scrolling display. Accepts ASCII characters one per handshake, encodes each to an active-low seven-segment pattern, and stores them in a double-buffered message store. The scroller reads the store through a registered read port; a completed message becomes visible to it atomically, so the scroller never shows a partially written message.

---
 rtl/sign_pkg.sv | 41 ++++
 rtl/sign_message_writer_seg_encoder.sv | 62 ++++++
 rtl/sign_message_writer.sv | 147 ++++++++++++++
 tb/tb_sign_message_writer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sign_pkg.sv
// Definitions shared by the relay-sign message writer and scroller.
// Segment patterns are gfedcba, active-low; FSM state encodings live here too.
package sign_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;
   localparam logic [6:0] SEG_H = 7'b0001001;
   localparam logic [6:0] SEG_I = 7'b1111001;
   localparam logic [6:0] SEG_L = 7'b1000111;
   localparam logic [6:0] SEG_O = 7'b1000000;
   localparam logic [6:0] SEG_P = 7'b0001100;
   localparam logic [6:0] SEG_R = 7'b0101111;
   localparam logic [6:0] SEG_S = 7'b0010010;
   localparam logic [6:0] SEG_U = 7'b1000001;
   localparam logic [6:0] SEG_V = 7'b1000001;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2
   } wr_state_e;

endpackage

// File: rtl/sign_message_writer_seg_encoder.sv
// ASCII to active-low seven-segment encoder; case-insensitive.
// o_valid is low for characters the sign cannot display (pattern is then blank).
module seg_encoder
   import sign_pkg::*;
(
   input  logic [7:0] i_char,
   output logic [6:0] o_seg,
   output logic       o_valid
);

   logic [7:0] w_upper;

   // Fold lowercase letters onto uppercase
   always_comb begin
      w_upper = i_char;
      if ((i_char >= 8'h61) && (i_char <= 8'h7A)) begin
         w_upper = i_char - 8'h20;
      end else begin
         w_upper = i_char;
      end
   end

   // Character lookup
   always_comb begin
      o_seg   = SEG_BLANK;
      o_valid = 1'b1;
      case (w_upper)
         8'h30: o_seg = SEG_0;
         8'h31: o_seg = SEG_1;
         8'h32: o_seg = SEG_2;
         8'h33: o_seg = SEG_3;
         8'h34: o_seg = SEG_4;
         8'h35: o_seg = SEG_5;
         8'h36: o_seg = SEG_6;
         8'h37: o_seg = SEG_7;
         8'h38: o_seg = SEG_8;
         8'h39: o_seg = SEG_9;
         8'h41: o_seg = SEG_A;
         8'h42: o_seg = SEG_B;
         8'h43: o_seg = SEG_C;
         8'h44: o_seg = SEG_D;
         8'h45: o_seg = SEG_E;
         8'h46: o_seg = SEG_F;
         8'h48: o_seg = SEG_H;
         8'h49: o_seg = SEG_I;
         8'h4C: o_seg = SEG_L;
         8'h4F: o_seg = SEG_O;
         8'h50: o_seg = SEG_P;
         8'h52: o_seg = SEG_R;
         8'h53: o_seg = SEG_S;
         8'h55: o_seg = SEG_U;
         8'h56: o_seg = SEG_V;
         8'h20: o_seg = SEG_BLANK;
         8'h2D: o_seg = SEG_DASH;
         default: begin
            o_seg   = SEG_BLANK;
            o_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/sign_message_writer.sv
// Message-entry side of the relay sign: encodes incoming characters into a shadow
// bank and swaps it live atomically on commit; the scroller reads the active bank.
module sign_message_writer
   import sign_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [7:0]        wr_char,
   input  logic              wr_last,
   input  logic              clear,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [6:0]        rd_seg,
   output logic [ADDR_W:0]   msg_len,
   output logic              msg_swap,
   output logic              bad_char,
   output logic              overflow
);

   wr_state_e         r_state;
   wr_state_e         w_next_state;
   logic [6:0]        r_bank [0:1][0:DEPTH-1];
   logic              r_bank_sel;
   logic [ADDR_W:0]   r_wr_idx;
   logic [ADDR_W:0]   w_wr_idx_next;
   logic [ADDR_W:0]   r_msg_len;
   logic [6:0]        r_rd_seg;
   logic              r_msg_swap;
   logic              r_overflow;
   logic [6:0]        w_enc_seg;
   logic              w_enc_valid;
   logic              w_accept;
   logic              w_wr_en;
   logic              w_commit;
   logic              w_set_ovf;
   logic              w_at_end;
   logic              w_shadow_sel;

   seg_encoder u_seg_encoder (
      .i_char  (wr_char),
      .o_seg   (w_enc_seg),
      .o_valid (w_enc_valid)
   );

   assign wr_ready     = (r_state != ST_COMMIT);
   assign w_accept     = wr_valid & wr_ready;
   assign w_at_end     = (r_wr_idx == (ADDR_W+1)'(DEPTH-1));
   assign w_shadow_sel = ~r_bank_sel;

   // Next-state and write-control decode; clear outranks a same-cycle write
   always_comb begin
      w_next_state  = r_state;
      w_wr_idx_next = r_wr_idx;
      w_wr_en       = 1'b0;
      w_commit      = 1'b0;
      w_set_ovf     = 1'b0;
      case (r_state)
         ST_IDLE, ST_LOAD: begin
            if (clear) begin
               w_next_state  = ST_IDLE;
               w_wr_idx_next = '0;
            end else if (w_accept) begin
               w_wr_en       = 1'b1;
               w_wr_idx_next = r_wr_idx + (ADDR_W+1)'(1);
               if (wr_last || w_at_end) begin
                  w_next_state = ST_COMMIT;
                  w_set_ovf    = ~wr_last;
               end else begin
                  w_next_state = ST_LOAD;
               end
            end else begin
               w_next_state = r_state;
            end
         end
         ST_COMMIT: begin
            w_commit      = 1'b1;
            w_next_state  = ST_IDLE;
            w_wr_idx_next = '0;
         end
         default: begin
            w_next_state  = ST_IDLE;
            w_wr_idx_next = '0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Double-buffered message store; writes only ever touch the shadow bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DEPTH; i++) begin
               r_bank[b][i] <= SEG_BLANK;
            end
         end
      end else if (w_wr_en) begin
         r_bank[w_shadow_sel][r_wr_idx[ADDR_W-1:0]] <= w_enc_seg;
      end
   end

   // Write index, bank select, length, status flags and registered read port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_idx   <= '0;
         r_bank_sel <= 1'b0;
         r_msg_len  <= '0;
         r_msg_swap <= 1'b0;
         r_overflow <= 1'b0;
         r_rd_seg   <= SEG_BLANK;
      end else begin
         r_wr_idx   <= w_wr_idx_next;
         r_msg_swap <= w_commit;
         if (w_commit) begin
            r_bank_sel <= ~r_bank_sel;
            r_msg_len  <= r_wr_idx;
         end
         if (w_set_ovf) begin
            r_overflow <= 1'b1;
         end
         // Entries past the active length are masked rather than cleared
         if ({1'b0, rd_addr} < r_msg_len) begin
            r_rd_seg <= r_bank[r_bank_sel][rd_addr];
         end else begin
            r_rd_seg <= SEG_BLANK;
         end
      end
   end

   assign rd_seg   = r_rd_seg;
   assign msg_len  = r_msg_len;
   assign msg_swap = r_msg_swap;
   assign overflow = r_overflow;
   assign bad_char = w_wr_en & ~w_enc_valid;

endmodule

// File: tb/tb_sign_message_writer.sv
// Directed testbench for sign_message_writer with hand-computed segment patterns.
module tb_sign_message_writer;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b0;
   logic              wr_valid = 1'b0;
   logic [7:0]        wr_char  = 8'h00;
   logic              wr_last  = 1'b0;
   logic              clear    = 1'b0;
   logic [ADDR_W-1:0] rd_addr  = '0;
   logic              wr_ready;
   logic [6:0]        rd_seg;
   logic [ADDR_W:0]   msg_len;
   logic              msg_swap;
   logic              bad_char;
   logic              overflow;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sign_message_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_char  (wr_char),
      .wr_last  (wr_last),
      .clear    (clear),
      .rd_addr  (rd_addr),
      .rd_seg   (rd_seg),
      .msg_len  (msg_len),
      .msg_swap (msg_swap),
      .bad_char (bad_char),
      .overflow (overflow)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [7:0] c, input logic l, input logic clr);
      wr_valid = v;
      wr_char  = c;
      wr_last  = l;
      clear    = clr;
      #1;
   endtask

   task automatic rd(input int a, input logic [6:0] exp, input string tag);
      rd_addr = a[ADDR_W-1:0];
      tick();
      check_eq(tag, {25'd0, rd_seg}, {25'd0, exp});
   endtask

   initial begin
      string digits;
      digits = "0123456789ABCDEF";

      // reset state
      #12;
      check_eq("rst_ready",    {31'd0, wr_ready}, 32'd1);
      check_eq("rst_rd_seg",   {25'd0, rd_seg},   32'h7F);
      check_eq("rst_msg_len",  {27'd0, msg_len},  32'd0);
      check_eq("rst_swap",     {31'd0, msg_swap}, 32'd0);
      check_eq("rst_bad",      {31'd0, bad_char}, 32'd0);
      check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
      #1;
      rst_n = 1'b1;
      tick();

      // "CAR"
      drv(1'b1, "C", 1'b0, 1'b0);
      tick();
      drv(1'b1, "A", 1'b0, 1'b0);
      tick();
      drv(1'b1, "R", 1'b1, 1'b0);
      tick();
      drv(1'b0, 8'h00, 1'b0, 1'b0);
      rd_addr = 4'd0;
      check_eq("car_commit_ready", {31'd0, wr_ready}, 32'd0);
      check_eq("car_commit_swap",  {31'd0, msg_swap}, 32'd0);
      tick();
      check_eq("car_swap",       {31'd0, msg_swap}, 32'd1);
      check_eq("car_len",        {27'd0, msg_len},  32'd3);
      check_eq("car_ready_back", {31'd0, wr_ready}, 32'd1);
      check_eq("car_rd_in_commit", {25'd0, rd_seg}, 32'h7F);
      rd(0, 7'b1000110, "car_rd0");
      check_eq("car_swap_once", {31'd0, msg_swap}, 32'd0);
      rd(1, 7'b0001000, "car_rd1");
      rd(2, 7'b0101111, "car_rd2");
      rd(3, 7'b1111111, "car_rd3");

      // "Hi" with a one-cycle gap
      drv(1'b1, "H", 1'b0, 1'b0);
      tick();
      drv(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      drv(1'b1, "i", 1'b1, 1'b0);
      check_eq("hi_ready_before", {31'd0, wr_ready}, 32'd1);
      check_eq("hi_bad_lower",    {31'd0, bad_char}, 32'd0);
      tick();
      check_eq("hi_ready_low", {31'd0, wr_ready}, 32'd0);
      drv(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      check_eq("hi_swap", {31'd0, msg_swap}, 32'd1);
      check_eq("hi_len",  {27'd0, msg_len},  32'd2);
      rd(0, 7'b0001001, "hi_rd0");
      rd(1, 7'b1111001, "hi_rd1");
      rd(2, 7'b1111111, "hi_rd2");

      // 17 characters with no wr_last
      for (int i = 0; i < DEPTH; i++) begin
         drv(1'b1, digits[i], 1'b0, 1'b0);
         tick();
      end
      check_eq("ovf_set",        {31'd0, overflow}, 32'd1);
      check_eq("ovf_commit_rdy", {31'd0, wr_ready}, 32'd0);
      drv(1'b1, "P", 1'b0, 1'b0);
      tick();
      check_eq("ovf_swap",  {31'd0, msg_swap}, 32'd1);
      check_eq("ovf_len",   {27'd0, msg_len},  32'd16);
      check_eq("ovf_ready", {31'd0, wr_ready}, 32'd1);
      rd_addr = 4'd0;
      tick();
      check_eq("ovf_rd0", {25'd0, rd_seg}, 32'b1000000);
      drv(1'b0, 8'h00, 1'b0, 1'b0);
      rd(15, 7'b0001110, "ovf_rd15");
      rd(9, 7'b0010000, "ovf_rd9");
      drv(1'b1, "-", 1'b1, 1'b0);
      tick();
      drv(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      check_eq("p_len",    {27'd0, msg_len},  32'd2);
      check_eq("ovf_keep", {31'd0, overflow}, 32'd1);
      rd(0, 7'b0001100, "p_rd0");
      rd(1, 7'b0111111, "p_rd1");

      // clear after two characters while wr_valid is high
      drv(1'b1, "E", 1'b0, 1'b0);
      tick();
      drv(1'b1, "L", 1'b0, 1'b0);
      tick();
      drv(1'b1, "U", 1'b0, 1'b1);
      tick();
      check_eq("clr_swap0", {31'd0, msg_swap}, 32'd0);
      drv(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      check_eq("clr_swap1", {31'd0, msg_swap}, 32'd0);
      check_eq("clr_len",   {27'd0, msg_len},  32'd2);
      check_eq("clr_ready", {31'd0, wr_ready}, 32'd1);
      rd(0, 7'b0001100, "clr_old_rd0");
      drv(1'b1, "5", 1'b1, 1'b0);
      tick();
      drv(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      check_eq("clr_next_len", {27'd0, msg_len}, 32'd1);
      rd(0, 7'b0010010, "clr_next_rd0");
      rd(1, 7'b1111111, "clr_next_rd1");

      // unsupported character
      drv(1'b1, "2", 1'b0, 1'b0);
      check_eq("bad_good_char", {31'd0, bad_char}, 32'd0);
      tick();
      drv(1'b1, "#", 1'b1, 1'b0);
      check_eq("bad_pulse", {31'd0, bad_char}, 32'd1);
      tick();
      check_eq("bad_one_cycle", {31'd0, bad_char}, 32'd0);
      drv(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      check_eq("bad_len", {27'd0, msg_len}, 32'd2);
      rd(0, 7'b0100100, "bad_rd0");
      rd(1, 7'b1111111, "bad_rd1");

      // asynchronous reset mid-load
      drv(1'b1, "C", 1'b0, 1'b0);
      tick();
      drv(1'b0, 8'h00, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mrst_ready",    {31'd0, wr_ready}, 32'd1);
      check_eq("mrst_len",      {27'd0, msg_len},  32'd0);
      check_eq("mrst_rd_seg",   {25'd0, rd_seg},   32'h7F);
      check_eq("mrst_swap",     {31'd0, msg_swap}, 32'd0);
      check_eq("mrst_overflow", {31'd0, overflow}, 32'd0);
      #2;
      rst_n = 1'b1;
      rd(0, 7'b1111111, "mrst_rd0");
      check_eq("mrst_len_after", {27'd0, msg_len}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
